mult_div_sequencer: RTL and testbench
=====================================

Name: mult_div_sequencer

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage; owns the HI/LO register pair and services MFHI/MFLO/MTHI/MTLO.
- Iterative radix-2 engine: 1 bit per cycle, shift-add multiply and restoring divide, sign-magnitude handling for signed ops.
- Sits beside the ALU and is driven by the same 6-bit funct field. Raises a stall to the hazard logic while a request cannot be served.

Parameters:
- SIZE, 32, operand and HI/LO width.
- ALU_FUNC_SIZE, 6, funct field width.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  EX holds a HI/LO-class instruction this cycle.
- i_func  in  ALU_FUNC_SIZE  funct code: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. Any other code with i_start=1 is ignored.
- i_rs  in  SIZE  operand A (dividend/multiplicand); also the MTHI/MTLO data.
- i_rt  in  SIZE  operand B (divisor/multiplier).
- i_flush  in  1  kill the in-flight operation; HI/LO are left unchanged.
- o_hi  out  SIZE  HI register.
- o_lo  out  SIZE  LO register.
- o_busy  out  1  engine not IDLE.
- o_stall  out  1  combinational: i_start & o_busy & func is any of the 8 codes.
- o_done  out  1  one-cycle pulse after HI/LO are updated by an operation.

Behaviour:
- Reset: state=IDLE, HI=LO=0, counter=0, o_done=0, o_busy=0. Working registers are cleared. Reset mid-operation aborts the operation; HI/LO read 0.
- States: IDLE, RUN, FIX.
- IDLE, i_start=1, func=MULT/MULTU/DIV/DIVU, i_flush=0:
  - latch |A| and |B| (raw values for unsigned ops) and the result sign flags;
  - set counter=SIZE-1; go to RUN.
- IDLE, i_start=1, func=MTHI/MTLO: write i_rs into HI or LO at this edge; stay IDLE.
- MFHI/MFLO: served combinationally from o_hi/o_lo when not stalled; no state change.
- RUN, one step per edge:
  - Multiply: 2*SIZE-bit product accumulator, add-and-shift.
  - Divide: restoring step; the remainder shifts in the dividend MSB; subtract the divisor if the remainder is ≥ divisor; the quotient bit is 1 when the subtraction happens.
  - The counter decrements each edge. The edge at which the counter=0 moves the state to FIX, giving exactly SIZE RUN edges.
- FIX, one edge:
  - apply the two's-complement sign correction;
  - multiply: HI=product[2S-1:S], LO=product[S-1:0];
  - divide: LO=quotient (sign = sign A xor sign B), HI=remainder (sign = sign A);
  - go to IDLE and register o_done=1 for the next cycle.
- Latency: start accepted at edge 0, HI/LO written at edge SIZE+1 (33), o_done high during the cycle after edge 33.
- o_busy = (state != IDLE). o_busy is high for cycles 1..33, and a new start is accepted in the cycle o_done is high.
- A start while busy is not accepted: o_stall=1 and the pipeline holds EX, so the request is re-presented until the engine is IDLE.
- i_flush in RUN/FIX returns the state to IDLE on that edge: no HI/LO write, no o_done. i_flush wins over FIX completion on the same edge. i_flush with i_start in IDLE means the start is not accepted.
- Divide by zero (|B|=0): no special case; result is what the restoring algorithm plus sign correction produces. For DIVU this gives LO=all ones and HI=dividend.
- Signed overflow, 0x80000000 / -1: LO=0x80000000, HI=0.
- All arithmetic is modulo 2^SIZE per register. No exceptions are raised.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> o_done in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_busy=1 for cycles 1..33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV started, then MFLO presented at cycle 5 -> o_stall=1 through cycle 33. o_stall=0 at cycle 34 and o_lo holds the quotient. A MULT presented during busy is not accepted.
- MTHI 0x1234 while IDLE -> HI=0x1234 next cycle. i_flush at cycle 10 of a MULT -> IDLE, HI stays 0x1234, no o_done.
- i_rst asserted asynchronously at cycle 20 of a DIVU (prior HI/LO nonzero) -> immediately o_busy=0, o_hi=o_lo=0. After release, a new MULTU 3×5 gives LO=15, HI=0.

Source files
------------

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
// Iterative HI/LO unit that sits beside the ALU in the EX stage. It executes
// MULT/MULTU/DIV/DIVU one bit per clock: shift-add for multiply, restoring
// division for divide. Signed operands are handled as sign + magnitude, and the
// sign is applied in a final FIX cycle. The unit also owns the HI/LO pair and
// services MTHI/MTLO (write) and MFHI/MFLO (read straight from o_hi/o_lo).
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset
//   i_start  EX holds a HI/LO-class instruction this cycle
//   i_func   funct code (MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO)
//   i_rs     operand A (multiplicand/dividend), MTHI/MTLO data
//   i_rt     operand B (multiplier/divisor)
//   i_flush  kill the in-flight operation, HI/LO untouched
//   o_hi     HI register
//   o_lo     LO register
//   o_busy   engine is not idle
//   o_stall  a HI/LO request arrived while the engine is busy
//   o_done   one-cycle pulse after an operation has written HI/LO
//
// Timing: start accepted at edge 0, RUN edges 1..SIZE, FIX edge SIZE+1
// writes HI/LO, and o_done is high for the cycle after that.
module mult_div_sequencer #(
    parameter int SIZE          = 32,
    parameter int ALU_FUNC_SIZE = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [ALU_FUNC_SIZE-1:0] i_func,
    input  logic [SIZE-1:0]          i_rs,
    input  logic [SIZE-1:0]          i_rt,
    input  logic                     i_flush,
    output logic [SIZE-1:0]          o_hi,
    output logic [SIZE-1:0]          o_lo,
    output logic                     o_busy,
    output logic                     o_stall,
    output logic                     o_done
);

    localparam int CW = $clog2(SIZE);

    localparam logic [ALU_FUNC_SIZE-1:0] F_MULT  = ALU_FUNC_SIZE'(6'b011000);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MULTU = ALU_FUNC_SIZE'(6'b011001);
    localparam logic [ALU_FUNC_SIZE-1:0] F_DIV   = ALU_FUNC_SIZE'(6'b011010);
    localparam logic [ALU_FUNC_SIZE-1:0] F_DIVU  = ALU_FUNC_SIZE'(6'b011011);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MFHI  = ALU_FUNC_SIZE'(6'b010000);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MTHI  = ALU_FUNC_SIZE'(6'b010001);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MFLO  = ALU_FUNC_SIZE'(6'b010010);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MTLO  = ALU_FUNC_SIZE'(6'b010011);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Two's-complement negation at register width.
    function automatic logic [SIZE-1:0] neg_w(input logic [SIZE-1:0] v);
        return ~v + SIZE'(1'b1);
    endfunction

    // Two's-complement negation at product width.
    function automatic logic [2*SIZE-1:0] neg_2w(input logic [2*SIZE-1:0] v);
        return ~v + (2*SIZE)'(1'b1);
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic                busy_r;
    logic                done_r;
    logic [SIZE-1:0]     hi_r;
    logic [SIZE-1:0]     lo_r;

    // Working registers. acc_r holds {partial product, multiplier} for
    // multiply and {remainder, dividend/quotient} for divide.
    logic [2*SIZE-1:0]   acc_r;
    logic [SIZE-1:0]     opnd_r;
    logic                is_div_r;
    logic                neg_lo_r;
    logic                neg_hi_r;

    // Decode and control strobes.
    logic                is_arith_s;
    logic                is_div_s;
    logic                is_signed_s;
    logic                is_valid_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic [SIZE-1:0]     mag_a_s;
    logic [SIZE-1:0]     mag_b_s;
    logic                accept_s;
    logic                mthi_wr_s;
    logic                mtlo_wr_s;
    logic                step_s;
    logic                fix_s;

    // Datapath combinational results.
    logic [SIZE:0]       mul_sum_s;
    logic [SIZE:0]       rem_shift_s;
    logic [SIZE-1:0]     rem_new_s;
    logic                q_bit_s;
    logic [2*SIZE-1:0]   step_val_s;
    logic [2*SIZE-1:0]   prod_fix_s;
    logic [SIZE-1:0]     fix_hi_s;
    logic [SIZE-1:0]     fix_lo_s;

    // Function decode and operand magnitudes.
    always_comb begin
        is_arith_s  = 1'b0;
        is_valid_s  = 1'b0;
        case (i_func)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                is_arith_s = 1'b1;
                is_valid_s = 1'b1;
            end
            F_MFHI, F_MTHI, F_MFLO, F_MTLO: begin
                is_arith_s = 1'b0;
                is_valid_s = 1'b1;
            end
            default: begin
                is_arith_s = 1'b0;
                is_valid_s = 1'b0;
            end
        endcase
        // MULT/DIV have funct bit 0 clear, DIV/DIVU have bit 1 set.
        is_div_s    = i_func[1];
        is_signed_s = ~i_func[0];
        sign_a_s    = is_signed_s & i_rs[SIZE-1];
        sign_b_s    = is_signed_s & i_rt[SIZE-1];
        mag_a_s     = sign_a_s ? neg_w(i_rs) : i_rs;
        mag_b_s     = sign_b_s ? neg_w(i_rt) : i_rt;
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; flush always wins, including over FIX completion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == '0) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output strobes.
    always_comb begin
        accept_s  = 1'b0;
        mthi_wr_s = 1'b0;
        mtlo_wr_s = 1'b0;
        step_s    = 1'b0;
        fix_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start && !i_flush) begin
                    accept_s  = is_arith_s;
                    mthi_wr_s = (i_func == F_MTHI);
                    mtlo_wr_s = (i_func == F_MTLO);
                end else begin
                    accept_s  = 1'b0;
                end
            end
            ST_RUN: begin
                step_s = ~i_flush;
            end
            ST_FIX: begin
                fix_s = ~i_flush;
            end
            default: begin
                step_s = 1'b0;
            end
        endcase
    end

    // One radix-2 step for either algorithm, plus the final sign correction.
    always_comb begin
        // Multiply: add multiplicand to the upper half when the LSB is set,
        // then shift the whole accumulator right with the carry.
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*SIZE-1:SIZE]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*SIZE-1:SIZE]};
        end
        // Divide: remainder shifts in the dividend MSB; subtract if it fits.
        rem_shift_s = acc_r[2*SIZE-1:SIZE-1];
        if (rem_shift_s >= {1'b0, opnd_r}) begin
            rem_new_s = rem_shift_s[SIZE-1:0] - opnd_r;
            q_bit_s   = 1'b1;
        end else begin
            rem_new_s = rem_shift_s[SIZE-1:0];
            q_bit_s   = 1'b0;
        end
        if (is_div_r) begin
            step_val_s = {rem_new_s, acc_r[SIZE-2:0], q_bit_s};
        end else begin
            step_val_s = {mul_sum_s, acc_r[SIZE-1:1]};
        end

        prod_fix_s = neg_lo_r ? neg_2w(acc_r) : acc_r;
        if (is_div_r) begin
            fix_lo_s = neg_lo_r ? neg_w(acc_r[SIZE-1:0]) : acc_r[SIZE-1:0];
            fix_hi_s = neg_hi_r ? neg_w(acc_r[2*SIZE-1:SIZE]) : acc_r[2*SIZE-1:SIZE];
        end else begin
            fix_lo_s = prod_fix_s[SIZE-1:0];
            fix_hi_s = prod_fix_s[2*SIZE-1:SIZE];
        end
    end

    // Working registers and iteration counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_r    <= '0;
            opnd_r   <= '0;
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            cnt_r    <= '0;
        end else if (accept_s) begin
            // Divide keeps the dividend in the low half; multiply the multiplier.
            acc_r    <= {{SIZE{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
            opnd_r   <= is_div_s ? mag_b_s : mag_a_s;
            is_div_r <= is_div_s;
            neg_lo_r <= sign_a_s ^ sign_b_s;
            neg_hi_r <= sign_a_s;
            cnt_r    <= CW'(SIZE-1);
        end else if (step_s) begin
            acc_r    <= step_val_s;
            cnt_r    <= cnt_r - CW'(1'b1);
        end else begin
            acc_r    <= acc_r;
            cnt_r    <= cnt_r;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (mthi_wr_s) begin
            hi_r <= i_rs;
        end else if (mtlo_wr_s) begin
            lo_r <= i_rs;
        end else if (fix_s) begin
            hi_r <= fix_hi_s;
            lo_r <= fix_lo_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Registered status: busy mirrors the next state, done follows a FIX write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= fix_s;
        end
    end

    assign o_hi    = hi_r;
    assign o_lo    = lo_r;
    assign o_busy  = busy_r;
    assign o_done  = done_r;
    assign o_stall = i_start & busy_r & is_valid_s;

endmodule

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_sequencer #(.SIZE(32), .ALU_FUNC_SIZE(6)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_func  (func),
        .i_rs    (rs),
        .i_rt    (rt),
        .i_flush (flush),
        .o_hi    (hi),
        .o_lo    (lo),
        .o_busy  (busy),
        .o_stall (stall),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results from plain 64-bit arithmetic.
    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] ehi, output logic [31:0] elo);
        logic [63:0] p;
        longint      q;
        longint      r;
        ehi = 32'h0;
        elo = 32'h0;
        case (f)
            F_MULTU: begin
                p   = {32'h0, a} * {32'h0, b};
                ehi = p[63:32];
                elo = p[31:0];
            end
            F_MULT: begin
                p   = longint'($signed(a)) * longint'($signed(b));
                ehi = p[63:32];
                elo = p[31:0];
            end
            F_DIVU: begin
                if (b == 32'h0) begin
                    elo = 32'hFFFF_FFFF;
                    ehi = a;
                end else begin
                    elo = a / b;
                    ehi = a % b;
                end
            end
            F_DIV: begin
                if (b == 32'h0) begin
                    // quotient all ones negated when A<0, remainder -|A| = A
                    elo = a[31] ? 32'h1 : 32'hFFFF_FFFF;
                    ehi = a;
                end else begin
                    q   = longint'($signed(a)) / longint'($signed(b));
                    r   = longint'($signed(a)) % longint'($signed(b));
                    p   = q;
                    elo = p[31:0];
                    p   = r;
                    ehi = p[31:0];
                end
            end
            default: begin
                ehi = 32'h0;
                elo = 32'h0;
            end
        endcase
    endfunction

    // Issue one operation and follow it to o_done, checking latency and results.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        int busy_n;
        int done_c;
        start = 1'b1; func = f; rs = a; rt = b;
        tick();
        start = 1'b0; func = 6'h0;
        cyc = 1; busy_n = 0; done_c = 0;
        while (done_c == 0 && cyc <= 40) begin
            if (busy) busy_n++;
            if (done) begin
                done_c = cyc;
            end else begin
                tick();
                cyc++;
            end
        end
        check_val({tag, "_done_cycle"}, 64'(done_c), 64'd34);
        check_val({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        check_val({tag, "_hi"}, {32'h0, hi}, {32'h0, ehi});
        check_val({tag, "_lo"}, {32'h0, lo}, {32'h0, elo});
    endtask

    // Flush a MULT at cycle n; nothing may be written or signalled.
    task automatic flush_at(input string tag, input int n);
        int done_n;
        start = 1'b1; func = F_MULT; rs = 32'd9; rt = 32'd9;
        tick();
        start = 1'b0;
        for (int c = 1; c < n; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val({tag, "_busy"}, {63'h0, busy}, 64'h0);
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_n++;
            tick();
        end
        check_val({tag, "_no_done"}, 64'(done_n), 64'h0);
        check_val({tag, "_hi"}, {32'h0, hi}, 64'h1234);
        check_val({tag, "_lo"}, {32'h0, lo}, 64'h5678);
    endtask

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        int          stall_n;

        rst = 1'b1; start = 1'b0; flush = 1'b0; func = 6'h0; rs = 32'h0; rt = 32'h0;
        #12;
        check_val("rst_hi", {32'h0, hi}, 64'h0);
        check_val("rst_lo", {32'h0, lo}, 64'h0);
        check_val("rst_busy", {63'h0, busy}, 64'h0);
        check_val("rst_done", {63'h0, done}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", F_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // MFLO held from cycle 5 stalls until the engine is idle again.
        start = 1'b1; func = F_DIV; rs = 32'd100; rt = 32'd7;
        tick();
        start = 1'b0;
        stall_n = 0;
        for (int c = 1; c <= 34; c++) begin
            if (c >= 5) begin
                start = 1'b1; func = F_MFLO;
            end
            #1;
            if (c >= 5 && c <= 33 && stall) stall_n++;
            if (c == 34) begin
                check_val("mflo_stall34", {63'h0, stall}, 64'h0);
                check_val("mflo_lo34", {32'h0, lo}, 64'd14);
                check_val("mflo_hi34", {32'h0, hi}, 64'd2);
                check_val("mflo_done34", {63'h0, done}, 64'h1);
            end
            if (c < 34) tick();
        end
        start = 1'b0;
        check_val("mflo_stall_cycles", 64'(stall_n), 64'd29);

        // MULT presented while busy must not be accepted.
        tick();
        start = 1'b1; func = F_DIVU; rs = 32'd1000; rt = 32'd3;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            if (c >= 2 && c <= 33) begin
                start = 1'b1; func = F_MULT; rs = 32'd5; rt = 32'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            if (c == 34) check_val("busy_mult_done", {63'h0, done}, 64'h1);
            if (c < 34) tick();
        end
        start = 1'b0;
        tick();
        check_val("busy_mult_idle", {63'h0, busy}, 64'h0);
        check_val("busy_mult_lo", {32'h0, lo}, 64'd333);
        check_val("busy_mult_hi", {32'h0, hi}, 64'd1);

        // MTHI / MTLO
        start = 1'b1; func = F_MTHI; rs = 32'h1234;
        tick();
        start = 1'b0;
        check_val("mthi_hi", {32'h0, hi}, 64'h1234);
        start = 1'b1; func = F_MTLO; rs = 32'h5678;
        tick();
        start = 1'b0;
        check_val("mtlo_lo", {32'h0, lo}, 64'h5678);
        check_val("mtlo_hi_kept", {32'h0, hi}, 64'h1234);

        // Start with flush in IDLE is not accepted.
        start = 1'b1; flush = 1'b1; func = F_MULT; rs = 32'd3; rt = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0;
        check_val("idle_flush_busy", {63'h0, busy}, 64'h0);

        flush_at("flush10", 10);
        flush_at("flush_fix", 33);

        // Asynchronous reset in cycle 20 of a DIVU.
        start = 1'b1; func = F_DIVU; rs = 32'd500; rt = 32'd7;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", {63'h0, busy}, 64'h0);
        check_val("arst_hi", {32'h0, hi}, 64'h0);
        check_val("arst_lo", {32'h0, lo}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op("after_rst", F_MULTU, 32'd3, 32'd5, 32'h0, 32'd15);

        // Randomized back-to-back operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            f = 6'(24 + $urandom_range(0, 3));
            a = pick_opnd();
            b = pick_opnd();
            ref_op(f, a, b, ehi, elo);
            run_op($sformatf("rnd%0d_f%0h", i, f), f, a, b, ehi, elo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
